// File: rtl/vliw_regfile_sb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : vliw_regfile_sb
// Parametrised NR-read / NW-write register file with per-register RAW
// scoreboard and sticky write-collision flag. Optional macro
// VLIW_REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
// Rev    : 1.0
// ============================================================================
module vliw_regfile_sb #(
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int NR    = 2,
  parameter int NW    = 2
) (
  input  logic                clk,
  input  logic                nClr,
  input  logic [NR*AW-1:0]    ra,
  output logic [NR*DW-1:0]    rd,
  output logic [NR-1:0]       rrdy,
  input  logic [NW*AW-1:0]    wa,
  input  logic [NW*DW-1:0]    wd,
  input  logic [NW-1:0]       we,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [DEPTH-1:0]    busy,
  output logic                wcoll
);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic             r_wcoll;

  logic [DEPTH-1:0] w_wr_hit;
  logic [DW-1:0]    w_wr_data [DEPTH];
  logic             w_coll;

  // Per-register write resolution; scanning from the top port down lets the
  // lowest-index enabled port overwrite the selection last and so win.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      w_wr_hit[r]  = 1'b0;
      w_wr_data[r] = '0;
      for (int j = NW - 1; j >= 0; j--) begin
        if (we[j] && (wa[j*AW +: AW] == AW'(r))) begin
          w_wr_hit[r]  = 1'b1;
          w_wr_data[r] = wd[j*DW +: DW];
        end
      end
    end
  end

  always_comb begin
    w_coll = 1'b0;
    for (int j = 0; j < NW; j++) begin
      for (int k = j + 1; k < NW; k++) begin
        if (we[j] && we[k] && (wa[j*AW +: AW] == wa[k*AW +: AW]))
          w_coll = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nClr) begin
    if (!nClr) begin
      for (int r = 0; r < DEPTH; r++)
        r_mem[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++)
        if (w_wr_hit[r])
          r_mem[r] <= w_wr_data[r];
    end
  end

  // A reservation in the same cycle as a write belongs to a younger producer,
  // so it takes precedence over the write's clear.
  always_ff @(posedge clk or negedge nClr) begin
    if (!nClr) begin
      r_busy  <= '0;
      r_wcoll <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (rsv_en && (rsv_addr == AW'(r)))
          r_busy[r] <= 1'b1;
        else if (w_wr_hit[r])
          r_busy[r] <= 1'b0;
      end
      if (w_coll)
        r_wcoll <= 1'b1;
    end
  end

  assign busy  = r_busy;
  assign wcoll = r_wcoll;

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic [DW-1:0] w_rdata;
    logic          w_rrdy;

    assign w_ra = ra[i*AW +: AW];

`ifdef VLIW_REGFILE_BYPASS_EN
    always_comb begin
      w_rdata = r_mem[w_ra];
      w_rrdy  = ~r_busy[w_ra];
      for (int j = NW - 1; j >= 0; j--) begin
        if (we[j] && (wa[j*AW +: AW] == w_ra)) begin
          w_rdata = wd[j*DW +: DW];
          w_rrdy  = 1'b1;
        end
      end
    end
`else
    assign w_rdata = r_mem[w_ra];
    assign w_rrdy  = ~r_busy[w_ra];
`endif

    assign rd[i*DW +: DW] = w_rdata;
    assign rrdy[i]        = w_rrdy;
  end

endmodule
`default_nettype wire

// File: doc/vliw_regfile_sb.md
Name: vliw_regfile_sb

Overview:
- Parametrised multi-ported register file with a per-register scoreboard, successor to the 2R/2W 16x32 file.
- Width, depth, read-port count and write-port count are all parameters.
- Tracks in-flight producers per register (busy bits) so issue logic can stall on RAW hazards.
- Flags same-cycle write-address collisions.
- Sits between the VLIW issue stage (reads and reservations) and the FP/int writeback buses.

Parameters:
DW, 32, data width per register
DEPTH, 16, number of registers (power of 2, >=2)
AW, 4, address width; must equal log2(DEPTH)
NR, 2, number of read ports (1..8)
NW, 2, number of write ports (1..4)

Ports:
clk  in  1  clock, rising edge
nClr  in  1  asynchronous active-low reset
ra  in  NR*AW  read addresses; port i = ra[i*AW +: AW]
rd  out  NR*DW  read data; port i = rd[i*DW +: DW]
rrdy  out  NR  port i operand ready (target register not busy)
wa  in  NW*AW  write addresses, packed as ra
wd  in  NW*DW  write data, packed as rd
we  in  NW  write enables
rsv_en  in  1  reserve destination (mark busy) this cycle
rsv_addr  in  AW  register to reserve
busy  out  DEPTH  scoreboard vector, bit r = register r has pending producer
wcoll  out  1  sticky: two enabled write ports hit the same address in one cycle

Behaviour:
- Reset, nClr low, asynchronous: all registers = 0, busy = 0, wcoll = 0. rd therefore reads 0 and rrdy = all 1 immediately.
- Read path is combinational, zero latency: rd[i] = reg[ra[i]].
- rrdy[i] = !busy[ra[i]], except as modified by the optional feature.
- Write path is synchronous, rising clk. For each port j with we[j]=1, reg[wa[j]] <= wd[j].
- Write priority:
  - If several enabled ports target the same address, the lowest-index port wins; higher ports are dropped for that address.
  - This generalises "we1 beats we2".
- wcoll:
  - Set at clk edge when any pair j<k has we[j] & we[k] & wa[j]==wa[k].
  - Stays 1 until nClr; no other clear.
- Scoreboard, per register r, evaluated at clk edge:
  - clr_r = any enabled write port with wa==r.
  - set_r = rsv_en & rsv_addr==r.
  - busy[r] <= set_r ? 1 : (clr_r ? 0 : busy[r]).
  - Simultaneous reserve and write to the same r: reserve wins and busy stays 1, because the write belongs to the older producer. The data write still happens.
- Writes to a non-busy register are legal: data is updated and busy stays 0.
- Reserving an already-busy register is legal: busy stays 1 (WAW is handled by issue logic, not here).
- Multiple read ports may share an address; each returns identical data.
- Out-of-range addresses are impossible when AW = log2(DEPTH). DEPTH not a power of 2 is unsupported.
- Reset asserted mid-operation: same-cycle writes and reservations are discarded; state returns to the reset values above.

Optional Feature:
- Macro: VLIW_REGFILE_BYPASS_EN.
- Defined:
  - Same-cycle write-to-read forwarding: if any enabled write port has wa==ra[i], rd[i] = wd of the lowest-index such port; otherwise the stored value.
  - rrdy[i] = 1 when that forwarding hit exists, even if busy[ra[i]]=1.
  - Forwarding is combinational, in the same cycle as we.
- Not defined:
  - rd[i] returns the pre-edge stored value; new data is visible the cycle after the write.
  - rrdy[i] = !busy[ra[i]] only.

Test Plan:
1. Reset/read: after nClr pulse low, set ra port0=3, port1=15 -> rd both 0, rrdy=2'b11, busy=0, wcoll=0.
2. Dual write: we=2'b11, wa0=2 wd0=32'hAAAA0001, wa1=5 wd1=32'h5555_0002, one edge -> reads of regs 2 and 5 return those values. Then we=2'b11 with wa0=wa1=7, wd0=32'h1, wd1=32'h2 -> reg7=32'h1, wcoll=1 and remains 1 through later clean writes until reset.
3. Scoreboard: rsv_en=1, rsv_addr=9 -> busy[9]=1 next cycle and rrdy=0 for ra=9. Write wa0=9 wd0=32'hC0DE -> busy[9]=0 next cycle, rd=32'hC0DE.
4. Reserve-vs-write race: busy[4]=1; same cycle rsv_addr=4 plus write wa1=4 wd1=32'h77 -> reg4=32'h77, busy[4] stays 1.
5. Bypass, macro defined: reg6=32'h10, busy[6]=1, ra0=6, we0 with wa0=6 wd0=32'h20 -> in the same cycle rd0=32'h20, rrdy[0]=1. Macro undefined: rd0=32'h10, rrdy[0]=0, then rd0=32'h20 and rrdy[0]=1 the next cycle.
6. Async reset mid-write: nClr low between edges while we=1 and rsv_en=1 -> registers, busy and wcoll become 0 immediately; the pending write and reservation are not applied at the next edge.
